// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter and select sequencer for a 32-to-1 mux.
// One requester owns the mux at a time. The select bus is frozen for the whole
// grant. A dead GAP cycle follows every release, so the select never changes
// while a grant is visible downstream.
//
// Output contract: grant_valid_o is high exactly when grant_o is non-zero.
// sel_o changes only on the edge that raises grant_valid_o. There is no
// back-pressure: the grantee signals completion with done_i, or by dropping
// its request line.
module mux_sel_arbiter #(
  parameter int N_REQ    = 32,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_valid_o,
  output logic             timeout_o,
  // Observation outputs for checkers and benches.
  output logic [1:0]       state_o,
  output logic [SEL_W-1:0] ptr_o,
  output logic [7:0]       hold_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Value hold_cnt_q reaches in the final granted cycle before a forced release.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam bit         HOLD_EN   = (MAX_HOLD != 0);

  state_e              state_q;
  logic [SEL_W-1:0]    sel_q;
  logic [N_REQ-1:0]    grant_q;
  logic                grant_valid_q;
  logic                timeout_q;
  logic [SEL_W-1:0]    ptr_q;
  logic [7:0]          hold_cnt_q;

  logic [SEL_W-1:0]    sel_d;
  logic [N_REQ-1:0]    grant_d;
  logic                hit_max_d;
  logic                withdrawn_d;
  logic                release_d;
  logic                timeout_d;

  // Round-robin pick: the first set bit of r, scanning p, p+1, ..., wrapping.
  // The scan runs downward, so the last match written is the one nearest p.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] win;
    win  = p;
    cand = p;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = p + i[SEL_W-1:0];
      if (r[cand]) win = cand;
    end
    return win;
  endfunction

  // Winner and one-hot grant for a new grant, computed from the live request vector.
  always_comb begin
    sel_d   = rr_pick(req_i, ptr_q);
    grant_d = '0;
    grant_d[sel_d] = 1'b1;
  end

  // Release conditions while in GRANT. The timeout pulses only when the hold
  // limit is the sole reason for the release.
  always_comb begin
    hit_max_d   = HOLD_EN && (hold_cnt_q == HOLD_LAST);
    withdrawn_d = !req_i[sel_q];
    release_d   = done_i || withdrawn_d || hit_max_d;
    timeout_d   = hit_max_d && !done_i && !withdrawn_d;
  end

  // Arbiter FSM with registered outputs. Reset aborts any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_i) begin
            sel_q         <= sel_d;
            grant_q       <= grant_d;
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= '0;
            state_q       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          hold_cnt_q <= hold_cnt_q + 8'd1;
          if (release_d) begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= sel_q + {{(SEL_W-1){1'b0}}, 1'b1};
            timeout_q     <= timeout_d;
            state_q       <= ST_GAP;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel_o         = sel_q;
  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid_q;
  assign timeout_o     = timeout_q;
  assign state_o       = state_q;
  assign ptr_o         = ptr_q;
  assign hold_cnt_o    = hold_cnt_q;

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin arbiter and select sequencer for the 32-to-1 mux datapath. It takes up to 32 independent request lines and grants the shared mux output to one requester at a time. It drives the 5-bit select bus and guarantees the select stays stable for the whole grant. It also inserts a dead cycle between grants, so downstream logic never sees a select change while a grant is valid.

## Interface

Parameters:
- `N_REQ`, 32: number of requesters; fixed at 32 to match the mux width.
- `SEL_W`, 5: select width, log2(`N_REQ`).
- `MAX_HOLD`, 15: maximum cycles a grant may last before forced release; 0 disables the timeout. Legal range is 0..255.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  32: request vector, one bit per requester; level-sensitive.
- `done`  in  1: current grantee has finished; single-cycle pulse, sampled only in GRANT.
- `sel`  out  5: select bus to the mux; registered.
- `grant`  out  32: one-hot grant vector; registered; all-zero when no grant.
- `grant_valid`  out  1: high exactly when `grant` is non-zero.
- `timeout`  out  1: single-cycle pulse when a grant is force-released.

## Operation

- State machine: IDLE, GRANT, GAP.
- Registered state besides outputs:
  - `ptr` (5 bits): round-robin start pointer.
  - `hold_cnt` (8 bits): grant-duration counter.
- IDLE behaviour:
  - If `req` is all-zero, stay in IDLE.
  - Otherwise pick winner k = first set bit of `req`, scanning `ptr`, `ptr`+1, ..., 31, 0, ..., `ptr`-1.
  - Register `sel`=k, `grant`=1<<k, `grant_valid`=1, `hold_cnt`=0, and go to GRANT.
- GRANT: `sel` and `grant` are held constant; `hold_cnt` increments each cycle. Release occurs on the first cycle in which any of these holds:
  - (a) `done`=1;
  - (b) `req[sel]`=0, meaning the requester withdrew;
  - (c) `MAX_HOLD`≠0 and `hold_cnt`=`MAX_HOLD`-1.
- On release:
  - Clear `grant` and `grant_valid`.
  - Set `ptr`=(`sel`+1) mod 32; 31 wraps to 0.
  - Go to GAP.
- `timeout` is asserted for that one cycle only when release is caused solely by (c). If (a) or (b) holds in the same cycle, there is no timeout pulse.
- GAP: unconditionally go to IDLE next cycle; `req` is ignored.
- `sel` changes only on the IDLE→GRANT transition. It retains its last value through GAP and IDLE.
- `ptr` changes only on release.
- `done` outside GRANT is ignored.

## Timing

- Reset (asynchronous, immediate on `rst_n`=0):
  - `sel`=0, `grant`=0, `grant_valid`=0, `timeout`=0.
  - state=IDLE, `ptr`=0, `hold_cnt`=0.
- Reset assertion mid-GRANT aborts the grant with no GAP cycle. After reset, arbitration restarts from `ptr`=0.
- Grant latency: `req` seen high at edge t while in IDLE gives `grant_valid`=1 after edge t.
- Release latency: release condition true at edge t gives `grant_valid`=0 after edge t.
- Minimum spacing between successive grants: a 1-cycle GAP plus a 1-cycle IDLE, so 2 dead cycles.
- With timeout, a grant lasts exactly `MAX_HOLD` cycles of `grant_valid`=1. `timeout` is high on the clock cycle after the last granted cycle, coincident with GAP.
- Requests that appear or vanish during GRANT or GAP are not latched. Only the `req` value at the IDLE edge is used.
- All outputs are driven from flops; no combinational path exists from `req` or `done` to any output.

## Test plan

- Reset: hold `rst_n`=0 with random `req` → `sel`=0, `grant`=0, `grant_valid`=0, `timeout`=0. Assert `rst_n`=0 in the middle of a GRANT → all outputs clear with no clock edge required.
- Single requester: `req`=0x0000_0020 → after 1 edge `sel`=5, `grant`=0x20, `grant_valid`=1. Pulse `done` → next edge `grant`=0 and state GAP. Following cycle IDLE, then re-grant to 5 if `req` is still held.
- Full rotation: `req`=0xFFFF_FFFF held, `done` pulsed once per grant → grant order 0,1,2,...,31, then 0 (wrap). Adjacent grants are 3 cycles apart (grant, GAP, IDLE).
- Pointer priority: after a grant to 30 (`ptr`=31), `req` has bits 3 and 31 set → 31 granted first, then 3. `sel` stays at 30 through GAP and IDLE.
- Timeout: `MAX_HOLD`=4, `req[7]` held, no `done` → `grant_valid` high for exactly 4 cycles, `timeout` pulses once, `ptr`=8. Repeat with `done` in the 4th cycle → no `timeout` pulse.
- Withdrawal: grant to 12, then drop `req[12]` while `done`=0 → release on the next edge, `timeout`=0, `ptr`=13.
